// File: rtl/const_load_seq.sv
// Two-step constant materialiser: writes {imm,16'h0} through the LUI unit,
// then ORs in the low half, with write-port stall support.
module const_load_seq #(
    parameter bit SKIP_ZERO_LOW = 1'b1,
    parameter bit R0_HARDWIRED  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_rd,
    input  logic [31:0] req_value,
    output logic [15:0] lui_imm,
    input  logic [31:0] lui_result,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    input  logic        rf_busy,
    output logic        busy,
    output logic        done
);

    typedef enum logic [1:0] {IDLE, UPPER, LOWER} state_t;

    state_t      state, state_nxt;
    logic [4:0]  rd_q;
    logic [31:0] val_q;
    logic        done_q, done_nxt;
    logic        accept;

    // Ready is gated by reset so nothing can be accepted while held in reset.
    assign req_ready = rst_n && (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = done_q;
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        rf_we     = 1'b0;
        rf_waddr  = 5'd0;
        rf_wdata  = 32'd0;
        lui_imm   = 16'd0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (R0_HARDWIRED && (req_rd == 5'd0))
                        done_nxt = 1'b1;
                    else
                        state_nxt = UPPER;
                end
            end
            UPPER: begin
                rf_we    = 1'b1;
                rf_waddr = rd_q;
                rf_wdata = lui_result;
                lui_imm  = val_q[31:16];
                if (!rf_busy) begin
                    if (!SKIP_ZERO_LOW || (val_q[15:0] != 16'd0)) begin
                        state_nxt = LOWER;
                    end else begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            LOWER: begin
                rf_we    = 1'b1;
                rf_waddr = rd_q;
                rf_wdata = lui_result | {16'h0000, val_q[15:0]};
                lui_imm  = val_q[31:16];
                if (!rf_busy) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            rd_q   <= 5'd0;
            val_q  <= 32'd0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= done_nxt;
            if (accept) begin
                rd_q  <= req_rd;
                val_q <= req_value;
            end
        end
    end

endmodule

// File: tb/tb_const_load_seq.sv
// Directed bench for const_load_seq: scoreboarded register-file writes on a
// default instance and a SKIP_ZERO_LOW=0 instance sharing the same stimulus.
module tb_const_load_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic [4:0]  req_rd;
    logic [31:0] req_value;
    logic        rf_busy;

    logic        req_ready, rf_we, busy, done;
    logic [15:0] lui_imm;
    logic [31:0] lui_result, rf_wdata;
    logic [4:0]  rf_waddr;

    logic        req_ready2, rf_we2, busy2, done2;
    logic [15:0] lui_imm2;
    logic [31:0] lui_result2, rf_wdata2;
    logic [4:0]  rf_waddr2;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t q1[$];
    wr_t q2[$];
    int  compares = 0;
    int  errors   = 0;

    always #5 clk = ~clk;

    assign lui_result  = {lui_imm, 16'h0000};
    assign lui_result2 = {lui_imm2, 16'h0000};

    const_load_seq dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_rd(req_rd), .req_value(req_value), .lui_imm(lui_imm),
        .lui_result(lui_result), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .rf_busy(rf_busy), .busy(busy), .done(done)
    );

    const_load_seq #(.SKIP_ZERO_LOW(1'b0), .R0_HARDWIRED(1'b1)) dut_ns (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready2),
        .req_rd(req_rd), .req_value(req_value), .lui_imm(lui_imm2),
        .lui_result(lui_result2), .rf_we(rf_we2), .rf_waddr(rf_waddr2),
        .rf_wdata(rf_wdata2), .rf_busy(rf_busy), .busy(busy2), .done(done2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compares++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_load(input logic [4:0] rd, input logic [31:0] v);
        if (rd != 5'd0) begin
            q1.push_back('{rd, {v[31:16], 16'h0000}});
            if (v[15:0] != 16'd0) q1.push_back('{rd, v});
            q2.push_back('{rd, {v[31:16], 16'h0000}});
            q2.push_back('{rd, v});
        end
    endtask

    // Inputs change 1 time unit after posedge, so rf_busy seen here applies to the next edge.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n && rf_we && !rf_busy) begin
            if (q1.size() == 0) chk("dut_unexpected_write", 32'(rf_we), 32'd0);
            else begin
                e = q1.pop_front();
                chk("dut_wr_addr", 32'(rf_waddr), 32'(e.rd));
                chk("dut_wr_data", rf_wdata, e.data);
            end
        end
        if (rst_n && rf_we2 && !rf_busy) begin
            if (q2.size() == 0) chk("ns_unexpected_write", 32'(rf_we2), 32'd0);
            else begin
                e = q2.pop_front();
                chk("ns_wr_addr", 32'(rf_waddr2), 32'(e.rd));
                chk("ns_wr_data", rf_wdata2, e.data);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_rd = 5'd0; req_value = 32'd0; rf_busy = 1'b0;
        #3;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_we",    32'(rf_we),     32'd0);
        chk("rst_busy",  32'(busy),      32'd0);
        chk("rst_done",  32'(done),      32'd0);
        chk("rst_lui",   32'(lui_imm),   32'd0);
        chk("rst_waddr", 32'(rf_waddr),  32'd0);
        chk("rst_wdata", rf_wdata,       32'd0);
        #9 rst_n = 1'b1;
        cyc();
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        // Basic two-write load; inputs scrambled after accept must be ignored.
        req_valid = 1'b1; req_rd = 5'd5; req_value = 32'h1234_5678;
        expect_load(5'd5, 32'h1234_5678);
        cyc();
        req_valid = 1'b0; req_rd = 5'd31; req_value = 32'hDEAD_BEEF;
        nxt();
        chk("basic_c1_we",    32'(rf_we),    32'd1);
        chk("basic_c1_lui",   32'(lui_imm),  32'h1234);
        chk("basic_c1_waddr", 32'(rf_waddr), 32'd5);
        chk("basic_c1_busy",  32'(busy),     32'd1);
        chk("basic_c1_ready", 32'(req_ready), 32'd0);
        chk("basic_c1_done",  32'(done),     32'd0);
        cyc(); nxt();
        chk("basic_c2_wdata", rf_wdata, 32'h1234_5678);
        cyc(); nxt();
        chk("basic_c3_done",  32'(done),      32'd1);
        chk("basic_c3_ready", 32'(req_ready), 32'd1);
        chk("basic_c3_we",    32'(rf_we),     32'd0);
        cyc(); nxt();
        chk("basic_c4_done",  32'(done),      32'd0);

        // Skip-low: default instance writes once, the other writes twice.
        cyc();
        req_valid = 1'b1; req_rd = 5'd7; req_value = 32'hABCD_0000;
        expect_load(5'd7, 32'hABCD_0000);
        cyc();
        req_valid = 1'b0;
        nxt();
        chk("skip_c1_wdata", rf_wdata, 32'hABCD_0000);
        cyc(); nxt();
        chk("skip_c2_done",    32'(done),   32'd1);
        chk("skip_c2_we",      32'(rf_we),  32'd0);
        chk("ns_c2_we",        32'(rf_we2), 32'd1);
        chk("ns_c2_done",      32'(done2),  32'd0);
        cyc(); nxt();
        chk("ns_c3_done",      32'(done2),  32'd1);
        chk("skip_c3_done",    32'(done),   32'd0);

        // Three stalled cycles in UPPER while request inputs wiggle.
        cyc();
        req_valid = 1'b1; req_rd = 5'd9; req_value = 32'hCAFE_BABE;
        expect_load(5'd9, 32'hCAFE_BABE);
        cyc();
        rf_busy = 1'b1; req_rd = 5'd2; req_value = 32'h0101_0101;
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("stall_we",    32'(rf_we),    32'd1);
            chk("stall_waddr", 32'(rf_waddr), 32'd9);
            chk("stall_wdata", rf_wdata,      32'hCAFE_0000);
            chk("stall_lui",   32'(lui_imm),  32'hCAFE);
            chk("stall_done",  32'(done),     32'd0);
            cyc();
            req_value = req_value + 32'h1111;
        end
        rf_busy = 1'b0; req_valid = 1'b0;
        nxt();
        chk("stall_c4_wdata", rf_wdata, 32'hCAFE_0000);
        cyc(); nxt();
        chk("stall_c5_wdata", rf_wdata, 32'hCAFE_BABE);
        cyc(); nxt();
        chk("stall_c6_done",  32'(done), 32'd1);

        // r0 request, then back-to-back request accepted in the done cycle.
        cyc();
        req_valid = 1'b1; req_rd = 5'd0; req_value = 32'hFFFF_FFFF;
        cyc();
        req_rd = 5'd3; req_value = 32'h0000_0001;
        expect_load(5'd3, 32'h0000_0001);
        nxt();
        chk("r0_done",  32'(done),      32'd1);
        chk("r0_ready", 32'(req_ready), 32'd1);
        chk("r0_we",    32'(rf_we),     32'd0);
        cyc();
        req_valid = 1'b0;
        nxt();
        chk("b2b_c1_waddr", 32'(rf_waddr), 32'd3);
        chk("b2b_c1_wdata", rf_wdata,      32'h0000_0000);
        cyc(); nxt();
        chk("b2b_c2_wdata", rf_wdata,      32'h0000_0001);
        cyc(); nxt();
        chk("b2b_c3_done",  32'(done),     32'd1);

        // Reset in LOWER abandons the write.
        cyc();
        req_valid = 1'b1; req_rd = 5'd12; req_value = 32'h1357_2468;
        expect_load(5'd12, 32'h1357_2468);
        cyc();
        req_valid = 1'b0;
        nxt(); cyc(); nxt();
        chk("mid_lower_wdata", rf_wdata, 32'h1357_2468);
        #1 rst_n = 1'b0;
        q1.delete(); q2.delete();
        #1;
        chk("mid_rst_we",    32'(rf_we),     32'd0);
        chk("mid_rst_waddr", 32'(rf_waddr),  32'd0);
        chk("mid_rst_wdata", rf_wdata,       32'd0);
        chk("mid_rst_lui",   32'(lui_imm),   32'd0);
        chk("mid_rst_busy",  32'(busy),      32'd0);
        chk("mid_rst_ready", 32'(req_ready), 32'd0);
        cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            nxt();
            chk("post_rst_ready", 32'(req_ready), 32'd1);
            chk("post_rst_done",  32'(done),      32'd0);
            chk("post_rst_we",    32'(rf_we),     32'd0);
            cyc();
        end

        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
        $finish;
    end

endmodule
